// File: rtl/ddr_rd_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ddr_rd_ctrl_if                                                |
// | Brief    : AXI read address / read data channel bundle for ddr_rd_ctrl.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ddr_rd_ctrl_if #(
   parameter int DW = 256,
   parameter int IW = 8
);
   logic [IW-1:0] ARID;
   logic [31:0]   ARADDR;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE;
   logic [1:0]    ARBURST;
   logic [1:0]    ARLOCK;
   logic          ARVALID;
   logic          ARREADY;
   logic [IW-1:0] RID;
   logic [DW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ddr_rd_ctrl                                                   |
// | Brief    : Issues one AXI read burst per request and streams the beats   |
// |            to a downstream RAM port with protocol error tracking.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ddr_rd_ctrl #(
   parameter logic [7:0] AXI_RD_ID      = 8'h5a,
   parameter int         AXI_DATA_WIDTH = 256,
   parameter int         AXI_ID_WIDTH   = 8
) (
   input  wire logic                      clk,
   input  wire logic                      rst_n,
   input  wire logic                      burst_start,
   input  wire logic [31:0]               addr_i,
   input  wire logic [7:0]                burst_len_i,
   input  wire logic                      RamRdReady,
   output logic                           busy,
   output logic                           RamRdALoad,
   output logic                           RamRdWrEn,
   output logic [AXI_DATA_WIDTH-1:0]      RamRdData,
   output logic                           RamRdEnd,
   output logic                           rd_err,
   ddr_rd_ctrl_if.master                  axi
);

   localparam logic [AXI_ID_WIDTH-1:0] c_rd_id  = AXI_ID_WIDTH'(AXI_RD_ID);
   localparam logic [2:0]              c_arsize = 3'($clog2(AXI_DATA_WIDTH / 8));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_araddr;
   logic [7:0]  r_arlen;
   logic [7:0]  r_cnt;
   logic        r_arvalid;
   logic        r_busy;
   logic        r_end;
   logic        r_err;

   logic        w_rready;
   logic        w_beat;
   logic        w_cnt_zero;
   logic        w_term;
   logic        w_beat_bad;

   assign w_rready   = (r_state == S_DATA) & RamRdReady;
   assign w_beat     = axi.RVALID & w_rready;
   assign w_cnt_zero = (r_cnt == 8'd0);
   assign w_term     = w_beat & (axi.RLAST | w_cnt_zero);

   // A beat is bad on a bad response, a foreign ID, or RLAST disagreeing with the count.
   assign w_beat_bad = (axi.RRESP != 2'b00)
                     | (axi.RID != c_rd_id)
                     | (axi.RLAST & ~w_cnt_zero)
                     | (w_cnt_zero & ~axi.RLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_araddr  <= 32'd0;
         r_arlen   <= 8'd0;
         r_cnt     <= 8'd0;
         r_arvalid <= 1'b0;
         r_busy    <= 1'b0;
         r_end     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_end <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (burst_start) begin
                  r_araddr  <= addr_i;
                  r_arlen   <= burst_len_i;
                  r_arvalid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_err     <= 1'b0;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (r_arvalid && axi.ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_cnt     <= r_arlen;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  if (!w_cnt_zero) begin
                     r_cnt <= r_cnt - 8'd1;
                  end
                  if (w_beat_bad) begin
                     r_err <= 1'b1;
                  end
                  if (w_term) begin
                     r_busy  <= 1'b0;
                     r_end   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_arvalid <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign axi.ARID    = c_rd_id;
   assign axi.ARADDR  = r_araddr;
   assign axi.ARLEN   = r_arlen;
   assign axi.ARSIZE  = c_arsize;
   assign axi.ARBURST = 2'b01;
   assign axi.ARLOCK  = 2'b00;
   assign axi.ARVALID = r_arvalid;
   assign axi.RREADY  = w_rready;

   assign busy       = r_busy;
   assign RamRdALoad = r_arvalid & axi.ARREADY;
   assign RamRdWrEn  = w_beat;
   assign RamRdData  = axi.RDATA;
   assign RamRdEnd   = r_end;
   assign rd_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ddr_rd_ctrl                                                |
// | Brief    : Scoreboard bench acting as AXI read slave for ddr_rd_ctrl.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ddr_rd_ctrl;

   localparam int         c_dw = 256;
   localparam int         c_iw = 8;
   localparam logic [7:0] c_id = 8'h5a;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             burst_start;
   logic [31:0]      addr_i;
   logic [7:0]       burst_len_i;
   logic             RamRdReady;
   logic             busy;
   logic             RamRdALoad;
   logic             RamRdWrEn;
   logic [c_dw-1:0]  RamRdData;
   logic             RamRdEnd;
   logic             rd_err;

   ddr_rd_ctrl_if #(.DW(c_dw), .IW(c_iw)) axi ();

   ddr_rd_ctrl #(
      .AXI_RD_ID      (c_id),
      .AXI_DATA_WIDTH (c_dw),
      .AXI_ID_WIDTH   (c_iw)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .burst_start (burst_start),
      .addr_i      (addr_i),
      .burst_len_i (burst_len_i),
      .RamRdReady  (RamRdReady),
      .busy        (busy),
      .RamRdALoad  (RamRdALoad),
      .RamRdWrEn   (RamRdWrEn),
      .RamRdData   (RamRdData),
      .RamRdEnd    (RamRdEnd),
      .rd_err      (rd_err),
      .axi         (axi)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_beats = 0;
   int n_aload = 0;
   int n_end   = 0;
   int n_arv   = 0;
   logic [c_dw-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [c_dw-1:0] got, input logic [c_dw-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Downstream monitor: every delivered beat must match the next scoreboard entry.
   always @(negedge clk) begin
      if (RamRdWrEn) begin
         n_beats++;
         if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
         else chk("beat_data", RamRdData, exp_q.pop_front());
      end
      if (RamRdALoad) n_aload++;
      if (RamRdEnd) n_end++;
      if (axi.ARVALID) n_arv++;
   end

   task automatic start_burst(input logic [31:0] a, input logic [7:0] len);
      burst_start = 1'b1;
      addr_i      = a;
      burst_len_i = len;
      @(posedge clk); #1;
      burst_start = 1'b0;
   endtask

   task automatic send_beats(input int n, input int last_at, input int err_at, input bit toggle);
      for (int i = 0; i < n; i++) begin
         int guard;
         bit done;
         guard = 0;
         done  = 1'b0;
         axi.RVALID = 1'b1;
         axi.RDATA  = {8{$urandom()}};
         axi.RLAST  = (i == last_at);
         axi.RRESP  = (i == err_at) ? 2'b10 : 2'b00;
         axi.RID    = c_id;
         exp_q.push_back(axi.RDATA);
         while (!done) begin
            @(negedge clk);
            if (!RamRdReady) chk("rready_gated", {255'd0, axi.RREADY}, 0);
            if (axi.RVALID && axi.RREADY) begin
               done = 1'b1;
            end else begin
               guard++;
               if (guard > 50) begin
                  chk("beat_timeout", 0, 1);
                  done = 1'b1;
               end
            end
            @(posedge clk); #1;
            if (toggle) RamRdReady = ~RamRdReady;
         end
      end
      axi.RVALID = 1'b0;
      axi.RLAST  = 1'b0;
      axi.RRESP  = 2'b00;
   endtask

   task automatic finish_burst(input logic exp_err);
      @(negedge clk);
      chk("end_pulse", {255'd0, RamRdEnd}, 1);
      chk("busy_done", {255'd0, busy}, 0);
      chk("rd_err", {255'd0, rd_err}, {255'd0, exp_err});
      @(posedge clk); #1;
      @(negedge clk);
      chk("end_one_cycle", {255'd0, RamRdEnd}, 0);
      @(posedge clk); #1;
   endtask

   int b0, a0, l0, e0;

   initial begin
      rst_n       = 1'b0;
      burst_start = 1'b0;
      addr_i      = 32'd0;
      burst_len_i = 8'd0;
      RamRdReady  = 1'b1;
      axi.ARREADY = 1'b1;
      axi.RID     = c_id;
      axi.RDATA   = '0;
      axi.RRESP   = 2'b00;
      axi.RLAST   = 1'b0;
      axi.RVALID  = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_arvalid", {255'd0, axi.ARVALID}, 0);
      chk("rst_busy", {255'd0, busy}, 0);
      chk("rst_araddr", {224'd0, axi.ARADDR}, 0);
      chk("rst_arlen", {248'd0, axi.ARLEN}, 0);
      chk("const_arid", {248'd0, axi.ARID}, {248'd0, c_id});
      chk("const_arsize", {253'd0, axi.ARSIZE}, 5);
      chk("const_arburst", {254'd0, axi.ARBURST}, 1);
      chk("const_arlock", {254'd0, axi.ARLOCK}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4-beat burst with immediate address acceptance.
      b0 = n_beats; a0 = n_arv; l0 = n_aload;
      start_burst(32'h1000, 8'd3);
      @(negedge clk);
      chk("s1_araddr", {224'd0, axi.ARADDR}, 32'h1000);
      chk("s1_arlen", {248'd0, axi.ARLEN}, 3);
      chk("s1_busy", {255'd0, busy}, 1);
      chk("s1_aload", {255'd0, RamRdALoad}, 1);
      @(posedge clk); #1;
      send_beats(4, 3, -1, 1'b0);
      finish_burst(1'b0);
      chk("s1_arvalid_cycles", n_arv - a0, 1);
      chk("s1_beats", n_beats - b0, 4);
      chk("s1_aloads", n_aload - l0, 1);

      // Address channel stalled for 5 cycles; a stray burst_start must be ignored.
      axi.ARREADY = 1'b0;
      l0 = n_aload;
      start_burst(32'h0000_2040, 8'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("s2_arvalid", {255'd0, axi.ARVALID}, 1);
         chk("s2_araddr", {224'd0, axi.ARADDR}, 32'h0000_2040);
         chk("s2_arlen", {248'd0, axi.ARLEN}, 1);
         chk("s2_no_aload", {255'd0, RamRdALoad}, 0);
         @(posedge clk); #1;
         burst_start = (i == 1);
         addr_i      = 32'hdead_0000;
         burst_len_i = 8'd9;
      end
      burst_start = 1'b0;
      axi.ARREADY = 1'b1;
      @(negedge clk);
      chk("s2_aload", {255'd0, RamRdALoad}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s2_arvalid_drop", {255'd0, axi.ARVALID}, 0);
      chk("s2_aload_once", n_aload - l0, 1);
      @(posedge clk); #1;
      send_beats(2, 1, -1, 1'b0);
      finish_burst(1'b0);

      // Eight beats with downstream ready toggling.
      b0 = n_beats;
      start_burst(32'h0000_3000, 8'd7);
      send_beats(8, 7, -1, 1'b1);
      RamRdReady = 1'b1;
      finish_burst(1'b0);
      chk("s3_beats", n_beats - b0, 8);

      // Early RLAST on beat 2 of 4.
      b0 = n_beats;
      start_burst(32'h0000_4000, 8'd3);
      send_beats(2, 1, -1, 1'b0);
      finish_burst(1'b1);
      chk("s4_beats", n_beats - b0, 2);

      // Single beat with SLVERR; the new start clears the previous error.
      b0 = n_beats;
      start_burst(32'h0000_5000, 8'd0);
      @(negedge clk);
      chk("s5_err_cleared", {255'd0, rd_err}, 0);
      @(posedge clk); #1;
      send_beats(1, 0, 0, 1'b0);
      finish_burst(1'b1);
      chk("s5_beats", n_beats - b0, 1);

      // Reset in the middle of the data phase.
      start_burst(32'h0000_6000, 8'd3);
      send_beats(2, -1, -1, 1'b0);
      e0 = n_end;
      rst_n = 1'b0;
      @(negedge clk);
      chk("s6_arvalid", {255'd0, axi.ARVALID}, 0);
      chk("s6_busy", {255'd0, busy}, 0);
      chk("s6_rd_err", {255'd0, rd_err}, 0);
      chk("s6_araddr", {224'd0, axi.ARADDR}, 0);
      chk("s6_arlen", {248'd0, axi.ARLEN}, 0);
      chk("s6_rready", {255'd0, axi.RREADY}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("s6_no_end", n_end - e0, 0);
      b0 = n_beats;
      start_burst(32'h0000_7000, 8'd1);
      send_beats(2, 1, -1, 1'b0);
      finish_burst(1'b0);
      chk("s6_beats_after", n_beats - b0, 2);

      chk("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
